axi_rom_slave: RTL and testbench
================================

AXI_ROM_SLAVE -- requirements
Module: axi_rom_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 Parameter DATA_WIDTH, default 32, AXI data width; only 32 supported.
REQ-003 Parameter IDS_WIDTH, default 8, slave-side ID width.
REQ-004 Parameter LEN_WIDTH, default 4, burst length field width.
REQ-005 Parameter MEM_DEPTH, default 1024, number of 32-bit words.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 ARID  input  IDS_WIDTH  read address ID.
REQ-009 ARADDR  input  ADDR_WIDTH  byte start address.
REQ-010 ARLEN  input  LEN_WIDTH  beats minus one.
REQ-011 ARSIZE  input  3  bytes per beat, log2.
REQ-012 ARBURST  input  2  burst type.
REQ-013 ARVALID  input  1  address valid.
REQ-014 ARREADY  output  1  address accepted.
REQ-015 RID  output  IDS_WIDTH  echoed ID.
REQ-016 RDATA  output  DATA_WIDTH  read data.
REQ-017 RRESP  output  2  beat response.
REQ-018 RLAST  output  1  final beat.
REQ-019 RVALID  output  1  data valid.
REQ-020 RREADY  input  1  master accepts data.
REQ-021 load_en  input  1  backdoor word write strobe.
REQ-022 load_addr  input  log2(MEM_DEPTH)  backdoor word index.
REQ-023 load_data  input  DATA_WIDTH  backdoor word value.

Function
REQ-024 FSM states IDLE and READ; exactly one outstanding transaction.
REQ-025 ARREADY SHALL be 1 only in IDLE; IDLE->READ on ARVALID&&ARREADY, capturing ARID, ARADDR, ARLEN, ARSIZE, ARBURST.
REQ-026 First beat: RVALID=1 in cycle after AR handshake (latency 1); no idle cycle between beats while RREADY=1.
REQ-027 While RVALID=1 and RREADY=0, RID/RDATA/RRESP/RLAST SHALL hold stable.
REQ-028 Beat counter 0..ARLEN; RLAST=1 exactly on beat ARLEN; single beat (ARLEN=0) gives RLAST on first beat.
REQ-029 On last-beat handshake: READ->IDLE, RVALID=0 and ARREADY=1 next cycle; back-to-back transaction latency AR-to-RVALID stays 1.
REQ-030 Word index = addr[log2(MEM_DEPTH)+1:2]; FIXED (00) reuses start address every beat; INCR (01) adds 4 per beat, modulo 2^ADDR_WIDTH.
REQ-031 Beat whose byte address >= 4*MEM_DEPTH: RRESP=DECERR (11), RDATA=0; evaluated per beat, so INCR bursts crossing the top give OKAY then DECERR.
REQ-032 ARBURST WRAP (10) or reserved (11), or ARSIZE!=2: all ARLEN+1 beats RRESP=SLVERR (10), RDATA=0; SLVERR has priority over DECERR.
REQ-033 Otherwise RRESP=OKAY (00), RDATA=memory word.
REQ-034 load_en writes mem[load_addr] at clock edge, any state; same-cycle read of same word returns old value.
REQ-035 ARADDR[1:0] ignored for data selection; 4KB-boundary crossing not checked.

Reset
REQ-036 rst asserted: state IDLE, ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, beat counter 0.
REQ-037 ARREADY SHALL rise on first clk edge after rst deasserts.
REQ-038 rst mid-burst aborts immediately; remaining beats never issued.
REQ-039 Memory contents SHALL NOT be reset.

Structure
REQ-040 Shared package axi_pkg: width constants, burst encodings FIXED/INCR/WRAP, response encodings OKAY/EXOKAY/SLVERR/DECERR.
REQ-041 Sub-module rom_mem: MEM_DEPTH x 32 array, one synchronous write port, one synchronous read port.

Verification
REQ-042 Preload mem[0..3]=A0..A3; AR id=0x15 addr=0x0 len=3 INCR, RREADY=1 -> RVALID cycle after handshake, RDATA A0..A3 consecutive, RID=0x15, RRESP=0, RLAST on 4th.
REQ-043 Same burst, RREADY toggled 1,0,0,1 -> beats held stable while stalled, order preserved, no duplicate or lost beat.
REQ-044 AR addr=0xFF8 len=3 INCR, MEM_DEPTH=1024 -> RRESP 00,00,11,11, last two RDATA=0.
REQ-045 AR len=1 ARBURST=WRAP; then ARSIZE=1 INCR -> two beats each RRESP=10, RDATA=0.
REQ-046 AR addr=0x10 len=2 FIXED -> three beats all mem[4]; load_en to word 4 mid-burst -> following beats show new value.
REQ-047 rst asserted during beat 2 of len=7 burst -> RVALID=0 immediately, ARREADY=1 first edge after release, new burst returns correct data.

Source files
------------

// File: rtl/axi_pkg.sv
// AXI read-channel constants shared by the ROM slave.
// Burst/response encodings and the read-FSM state type.
package axi_pkg;

  localparam int AXI_DATA_W = 32;
  localparam int AXI_RESP_W = 2;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_SIZE_W = 3;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic {
    ST_IDLE,
    ST_READ
  } rd_state_e;

  // WRAP, the reserved burst and any non-word size are refused.
  function automatic logic req_slverr(
    input logic [1:0] burst,
    input logic [2:0] size
  );
    return burst[1] || (size != SIZE_WORD);
  endfunction

endpackage

// File: rtl/axi_rom_slave_if.sv
// AXI read address / read data channels of the ROM slave.
// master drives AR and RREADY, slave drives ARREADY and R.
interface axi_rom_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IDS_WIDTH  = 8,
  parameter int LEN_WIDTH  = 4
);

  logic [IDS_WIDTH-1:0]  ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [LEN_WIDTH-1:0]  ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [IDS_WIDTH-1:0]  RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output RREADY,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  RREADY,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID
  );

endinterface

// File: rtl/axi_rom_slave_rom_mem.sv
// Word array with a backdoor write port and a registered read port.
// The read register only changes on a read strobe, so data holds.
module rom_mem #(
  parameter int DEPTH = 1024,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Backdoor write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read sees the pre-write word when both hit the same index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_rom_slave.sv
// Single-outstanding AXI read slave over a backdoor-loaded ROM.
// One beat per cycle; response decided per beat from its address.
module axi_rom_slave
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IDS_WIDTH  = 8,
  parameter int LEN_WIDTH  = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  axi_rom_slave_if.slave               axi,
  input  logic                         load_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]        load_data
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH+1:0] TOP_BYTE =
    (ADDR_WIDTH+2)'(4 * MEM_DEPTH);

  rd_state_e             state_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [IDS_WIDTH-1:0]  rid_q;
  logic [1:0]            rresp_q;
  logic                  slverr_q;
  logic [1:0]            burst_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                  ar_hs;
  logic                  r_hs;
  logic                  adv;
  logic                  ar_slverr;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [LEN_WIDTH-1:0]  beat_d;
  logic                  rd_en;
  logic [AW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] rd_data;

  function automatic logic is_decerr(
    input logic [ADDR_WIDTH-1:0] a
  );
    return {2'b00, a} >= TOP_BYTE;
  endfunction

  function automatic logic [1:0] resp_of(
    input logic                  slv,
    input logic [ADDR_WIDTH-1:0] a
  );
    if (slv) return RESP_SLVERR;
    if (is_decerr(a)) return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  assign ar_hs     = axi.ARVALID && arready_q;
  assign r_hs      = rvalid_q && axi.RREADY;
  assign adv       = r_hs && !rlast_q;
  assign ar_slverr = req_slverr(axi.ARBURST, axi.ARSIZE);
  assign beat_d    = beat_q + LEN_WIDTH'(1);

  // Next beat address: FIXED repeats, INCR steps one word.
  always_comb begin
    addr_d = addr_q;
    if (burst_q != BURST_FIXED) addr_d = addr_q + ADDR_WIDTH'(4);
  end

  // Fetch the first beat on AR handshake, later beats on advance.
  always_comb begin
    rd_en  = ar_hs || adv;
    rd_idx = addr_d[AW+1:2];
    if (ar_hs) rd_idx = axi.ARADDR[AW+1:2];
  end

  rom_mem #(
    .DEPTH (MEM_DEPTH),
    .DW    (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (load_en),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .re_i    (rd_en),
    .raddr_i (rd_idx),
    .rdata_o (rd_data)
  );

  // Read FSM with registered handshake and beat attributes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rresp_q   <= RESP_OKAY;
      slverr_q  <= 1'b0;
      burst_q   <= BURST_FIXED;
      len_q     <= '0;
      beat_q    <= '0;
      addr_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            state_q   <= ST_READ;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= axi.ARID;
            len_q     <= axi.ARLEN;
            beat_q    <= '0;
            burst_q   <= axi.ARBURST;
            slverr_q  <= ar_slverr;
            addr_q    <= axi.ARADDR;
            rlast_q   <= (axi.ARLEN == '0);
            rresp_q   <= resp_of(ar_slverr, axi.ARADDR);
          end
        end
        ST_READ: begin
          if (r_hs) begin
            if (rlast_q) begin
              state_q   <= ST_IDLE;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
            end else begin
              beat_q  <= beat_d;
              addr_q  <= addr_d;
              rlast_q <= (beat_d == len_q);
              rresp_q <= resp_of(slverr_q, addr_d);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign axi.ARREADY = arready_q;
  assign axi.RVALID  = rvalid_q;
  assign axi.RLAST   = rlast_q;
  assign axi.RID     = rid_q;
  assign axi.RRESP   = rresp_q;
  assign axi.RDATA   = (rresp_q == RESP_OKAY) ? rd_data : '0;

endmodule

// File: tb/tb_axi_rom_slave.sv
// Bench for axi_rom_slave: vector table of bursts plus
// hand sequences for mid-burst load and mid-burst reset.
module tb_axi_rom_slave;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  axi_rom_slave_if #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .IDS_WIDTH  (8),
    .LEN_WIDTH  (4)
  ) bus ();

  axi_rom_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .IDS_WIDTH  (8),
    .LEN_WIDTH  (4),
    .MEM_DEPTH  (1024)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .axi       (bus),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [3:0]  pat;
    logic [1:0]  exp_resp0;
    int          exp_beats;
  } vec_t;

  beat_t       exp_q[$];
  logic [31:0] shadow [1024];
  vec_t        vecs [11];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    return 32'hA000_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Reference beats from the bench's own memory image.
  task automatic push_model(input logic [7:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [1:0] burst,
                            input logic [2:0] size);
    for (int b = 0; b <= int'(len); b++) begin
      beat_t       e;
      logic [31:0] a;
      logic        slv;
      a = (burst == 2'b00) ? addr : addr + 32'(4 * b);
      slv = burst[1] || (size != 3'd2);
      e.id = id;
      e.last = (b == int'(len));
      if (slv) e.resp = 2'b10;
      else if (a >= 32'h0000_1000) e.resp = 2'b11;
      else e.resp = 2'b00;
      e.data = (e.resp == 2'b00) ? shadow[a[11:2]] : 32'h0;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_burst(input string tag, input logic [7:0] id,
                           input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size,
                           input logic [3:0] pat, input int ld_cyc,
                           input logic [9:0] ld_a, input logic [31:0] ld_d,
                           output int beats, output logic [1:0] resp0);
    int    w;
    int    k;
    bit    done;
    bit    held;
    beat_t h;
    beat_t e;
    beats = 0;
    resp0 = 2'bxx;
    bus.ARID = id;
    bus.ARADDR = addr;
    bus.ARLEN = len;
    bus.ARBURST = burst;
    bus.ARSIZE = size;
    bus.ARVALID = 1'b1;
    w = 0;
    while (bus.ARREADY !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) chk({tag, " arready timeout"}, 32'(w), 32'd0);
    k = 0;
    done = 0;
    held = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      bus.ARVALID = 1'b0;
      if (k == 0) begin
        chk({tag, " latency rvalid"}, 32'(bus.RVALID), 32'd1);
        chk({tag, " arready busy"}, 32'(bus.ARREADY), 32'd0);
      end
      if (held) begin
        chk({tag, " hold rvalid"}, 32'(bus.RVALID), 32'd1);
        chk({tag, " hold rid"}, 32'(bus.RID), 32'(h.id));
        chk({tag, " hold rdata"}, bus.RDATA, h.data);
        chk({tag, " hold rresp"}, 32'(bus.RRESP), 32'(h.resp));
        chk({tag, " hold rlast"}, 32'(bus.RLAST), 32'(h.last));
      end
      load_en = (k == ld_cyc);
      load_addr = ld_a;
      load_data = ld_d;
      bus.RREADY = pat[k % 4];
      held = 0;
      if (bus.RVALID === 1'b1) begin
        if (bus.RREADY) begin
          if (beats == 0) resp0 = bus.RRESP;
          beats++;
          if (exp_q.size() == 0) begin
            chk({tag, " unexpected beat"}, 32'(beats), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s b%0d rid", tag, beats - 1),
                32'(bus.RID), 32'(e.id));
            chk($sformatf("%s b%0d rdata", tag, beats - 1),
                bus.RDATA, e.data);
            chk($sformatf("%s b%0d rresp", tag, beats - 1),
                32'(bus.RRESP), 32'(e.resp));
            chk($sformatf("%s b%0d rlast", tag, beats - 1),
                32'(bus.RLAST), 32'(e.last));
          end
          if (bus.RLAST === 1'b1) done = 1;
        end else begin
          held = 1;
          h.id = bus.RID;
          h.data = bus.RDATA;
          h.resp = bus.RRESP;
          h.last = bus.RLAST;
        end
      end
      k++;
    end
    load_en = 1'b0;
    if (!done) chk({tag, " burst timeout"}, 32'(k), 32'd0);
    chk({tag, " beats left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    bus.RREADY = 1'b0;
    chk({tag, " rvalid after last"}, 32'(bus.RVALID), 32'd0);
    chk({tag, " arready after last"}, 32'(bus.ARREADY), 32'd1);
  endtask

  initial begin
    int          nb;
    logic [1:0]  r0;
    logic [31:0] nv;
    beat_t       e;

    vecs[0]  = '{8'h15, 32'h0,        4'd3,  2'b01, 3'd2, 4'b1111, 2'b00, 4};
    vecs[1]  = '{8'h15, 32'h0,        4'd3,  2'b01, 3'd2, 4'b1001, 2'b00, 4};
    vecs[2]  = '{8'h03, 32'hFF8,      4'd3,  2'b01, 3'd2, 4'b1111, 2'b00, 4};
    vecs[3]  = '{8'h07, 32'h20,       4'd1,  2'b10, 3'd2, 4'b1111, 2'b10, 2};
    vecs[4]  = '{8'h08, 32'h20,       4'd1,  2'b01, 3'd1, 4'b1111, 2'b10, 2};
    vecs[5]  = '{8'h09, 32'h4,        4'd0,  2'b01, 3'd2, 4'b1111, 2'b00, 1};
    vecs[6]  = '{8'h0A, 32'h1000,     4'd2,  2'b00, 3'd2, 4'b1111, 2'b11, 3};
    vecs[7]  = '{8'h0B, 32'hFF8,      4'd1,  2'b11, 3'd2, 4'b1111, 2'b10, 2};
    vecs[8]  = '{8'h0C, 32'h103,      4'd15, 2'b01, 3'd2, 4'b0110, 2'b00, 16};
    vecs[9]  = '{8'h0D, 32'hFFFFFFFC, 4'd1,  2'b01, 3'd2, 4'b1101, 2'b11, 2};
    vecs[10] = '{8'h0E, 32'h10,       4'd2,  2'b00, 3'd2, 4'b1111, 2'b00, 3};

    rst = 1'b1;
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
    bus.ARID = '0;
    bus.ARADDR = '0;
    bus.ARLEN = '0;
    bus.ARSIZE = '0;
    bus.ARBURST = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;

    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      load_en = 1'b1;
      load_addr = 10'(i);
      load_data = word_of(i);
      shadow[i] = word_of(i);
    end
    @(negedge clk);
    load_en = 1'b0;
    @(negedge clk);

    chk("rst arready", 32'(bus.ARREADY), 32'd0);
    chk("rst rvalid", 32'(bus.RVALID), 32'd0);
    chk("rst rlast", 32'(bus.RLAST), 32'd0);
    chk("rst rid", 32'(bus.RID), 32'd0);
    chk("rst rdata", bus.RDATA, 32'd0);
    chk("rst rresp", 32'(bus.RRESP), 32'd0);

    rst = 1'b0;
    chk("release arready pre-edge", 32'(bus.ARREADY), 32'd0);
    @(negedge clk);
    chk("release arready", 32'(bus.ARREADY), 32'd1);

    for (int i = 0; i < 11; i++) begin
      push_model(vecs[i].id, vecs[i].addr, vecs[i].len,
                 vecs[i].burst, vecs[i].size);
      run_burst($sformatf("vec%0d", i), vecs[i].id, vecs[i].addr,
                vecs[i].len, vecs[i].burst, vecs[i].size, vecs[i].pat,
                -1, 10'd0, 32'd0, nb, r0);
      chk($sformatf("vec%0d beat count", i), 32'(nb),
          32'(vecs[i].exp_beats));
      chk($sformatf("vec%0d first resp", i), 32'(r0),
          32'(vecs[i].exp_resp0));
    end

    // FIXED burst with a backdoor write while beat 0 is stalled.
    nv = 32'h5EED_0004;
    e = '{8'h31, shadow[4], 2'b00, 1'b0};
    exp_q.push_back(e);
    shadow[4] = nv;
    e = '{8'h31, nv, 2'b00, 1'b0};
    exp_q.push_back(e);
    e = '{8'h31, nv, 2'b00, 1'b1};
    exp_q.push_back(e);
    run_burst("fixed-load", 8'h31, 32'h10, 4'd2, 2'b00, 3'd2,
              4'b1110, 0, 10'd4, nv, nb, r0);
    chk("fixed-load beat count", 32'(nb), 32'd3);

    // Reset in the middle of an 8-beat burst.
    bus.ARID = 8'h21;
    bus.ARADDR = 32'h0;
    bus.ARLEN = 4'd7;
    bus.ARBURST = 2'b01;
    bus.ARSIZE = 3'd2;
    bus.ARVALID = 1'b1;
    bus.RREADY = 1'b1;
    chk("midrst arready", 32'(bus.ARREADY), 32'd1);
    @(negedge clk);
    bus.ARVALID = 1'b0;
    chk("midrst beat0 valid", 32'(bus.RVALID), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("midrst beat2 valid", 32'(bus.RVALID), 32'd1);
    chk("midrst beat2 data", bus.RDATA, shadow[2]);
    rst = 1'b1;
    #1;
    chk("midrst rvalid async", 32'(bus.RVALID), 32'd0);
    chk("midrst arready async", 32'(bus.ARREADY), 32'd0);
    chk("midrst rlast async", 32'(bus.RLAST), 32'd0);
    @(negedge clk);
    bus.RREADY = 1'b0;
    rst = 1'b0;
    chk("midrst arready held", 32'(bus.ARREADY), 32'd0);
    @(negedge clk);
    chk("midrst arready up", 32'(bus.ARREADY), 32'd1);
    chk("midrst no beats", 32'(bus.RVALID), 32'd0);
    push_model(8'h22, 32'h40, 4'd3, 2'b01, 3'd2);
    run_burst("post-rst", 8'h22, 32'h40, 4'd3, 2'b01, 3'd2,
              4'b1111, -1, 10'd0, 32'd0, nb, r0);
    chk("post-rst beat count", 32'(nb), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
